// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types, constants and mask helper for the dice roll engine
// FSM state encoding, LFSR taps, default seed and the rejection-sampling mask function.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DRAW,
    DONE
  } diceState_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Smallest all-ones value (2^k-1) covering maxVal, so masked draws hit 0..maxVal with minimal rejects.
  function automatic logic [31:0] dieMask(input logic [31:0] maxVal);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (m < maxVal) m = {m[30:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/dice_roll_engine_if.sv
// rtl/dice_roll_engine_if.sv - request/response bundle between decode logic and the roll engine
// The test_mode signal exists only when DICE_TEST_MODE_EN is defined.
interface dice_roll_engine_if #(
  parameter int MAX_SIDES = 100,
  parameter int MAX_COUNT = 8
);
  localparam int SIDE_W = $clog2(MAX_SIDES + 1);
  localparam int CNT_W  = $clog2(MAX_COUNT + 1);
  localparam int RES_W  = $clog2(MAX_COUNT * MAX_SIDES + 1);

  logic              start;
  logic [SIDE_W-1:0] sides;
  logic [CNT_W-1:0]  count;
`ifdef DICE_TEST_MODE_EN
  logic              test_mode;
`endif
  logic              busy;
  logic              done;
  logic              error;
  logic [RES_W-1:0]  result;
  logic [SIDE_W-1:0] last_die;

`ifdef DICE_TEST_MODE_EN
  modport master (output start, sides, count, test_mode,
                  input  busy, done, error, result, last_die);
  modport slave  (input  start, sides, count, test_mode,
                  output busy, done, error, result, last_die);
`else
  modport master (output start, sides, count,
                  input  busy, done, error, result, last_die);
  modport slave  (input  start, sides, count,
                  output busy, done, error, result, last_die);
`endif

endinterface

// File: rtl/dice_lfsr.sv
// rtl/dice_lfsr.sv - free-running right-shift Galois LFSR feeding the die sampler
// A zero seed is replaced by 1 so the register can never lock up.
module dice_lfsr
  import dice_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] state
);
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset) state <= SEED_NZ;
    else       state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/dice_roll_engine.sv
// rtl/dice_roll_engine.sv - NdS roll engine: rejection-sampled dice summed into result
// DICE_TEST_MODE_EN adds a test_mode input that replaces the LFSR with a deterministic counter.
module dice_roll_engine
  import dice_pkg::*;
#(
  parameter int                MAX_SIDES = 100,
  parameter int                MAX_COUNT = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED)
) (
  input logic               clk,
  input logic               reset,
  dice_roll_engine_if.slave bus
);
  localparam int SIDE_W = $clog2(MAX_SIDES + 1);
  localparam int CNT_W  = $clog2(MAX_COUNT + 1);
  localparam int RES_W  = $clog2(MAX_COUNT * MAX_SIDES + 1);

  diceState_t        state;
  logic [SIDE_W-1:0] sidesReg;
  logic [CNT_W-1:0]  remaining;
  logic [RES_W-1:0]  accum;
  logic [LFSR_W-1:0] lfsrState;

  logic              busyReg, doneReg, errorReg;
  logic [RES_W-1:0]  resultReg;
  logic [SIDE_W-1:0] lastDieReg;

  logic [31:0]       mask, cand;
  logic              accept, illegal;
  logic [SIDE_W-1:0] dieVal;

  dice_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsrState)
  );

`ifdef DICE_TEST_MODE_EN
  localparam int TC_W = SIDE_W + 1;
  logic [TC_W-1:0] tcnt;
`endif

  // remaining holds the captured count while in CHECK
  always_comb begin
    illegal = (int'(sidesReg) < 2) || (int'(sidesReg) > MAX_SIDES) ||
              (int'(remaining) == 0) || (int'(remaining) > MAX_COUNT);
    mask    = dieMask(32'(sidesReg) - 32'd1);
    cand    = 32'(lfsrState) & mask;
    accept  = cand < 32'(sidesReg);
    dieVal  = SIDE_W'(cand + 32'd1);
`ifdef DICE_TEST_MODE_EN
    if (bus.test_mode) begin
      accept = 1'b1;
      dieVal = (int'(tcnt) > int'(sidesReg)) ? SIDE_W'(1) : SIDE_W'(tcnt);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sidesReg   <= '0;
      remaining  <= '0;
      accum      <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      errorReg   <= 1'b0;
      resultReg  <= '0;
      lastDieReg <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sidesReg  <= bus.sides;
            remaining <= bus.count;
            accum     <= '0;
            busyReg   <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (illegal) begin
            errorReg  <= 1'b1;
            resultReg <= '0;
            doneReg   <= 1'b1;
            state     <= DONE;
          end else begin
            state <= DRAW;
          end
        end
        DRAW: begin
          if (accept) begin
            accum     <= accum + RES_W'(dieVal);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              errorReg   <= 1'b0;
              resultReg  <= accum + RES_W'(dieVal);
              lastDieReg <= dieVal;
              doneReg    <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DICE_TEST_MODE_EN
  // Counter survives across rolls so consecutive test rolls keep counting up.
  always_ff @(posedge clk) begin
    if (reset) tcnt <= TC_W'(1);
    else if (state == DRAW && bus.test_mode) tcnt <= TC_W'(dieVal) + TC_W'(1);
  end
`endif

  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.error    = errorReg;
  assign bus.result   = resultReg;
  assign bus.last_die = lastDieReg;

endmodule

// File: tb/tb_dice_roll_engine.sv
// tb/tb_dice_roll_engine.sv - directed self-checking bench for dice_roll_engine
// Test-mode steps run only when DICE_TEST_MODE_EN is defined.
module tb_dice_roll_engine;

  localparam int MAX_SIDES = 100;
  localparam int MAX_COUNT = 8;
  localparam int SW = $clog2(MAX_SIDES + 1);
  localparam int CW = $clog2(MAX_COUNT + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dice_roll_engine_if #(.MAX_SIDES(MAX_SIDES), .MAX_COUNT(MAX_COUNT)) bus ();

  dice_roll_engine #(
    .MAX_SIDES (MAX_SIDES),
    .MAX_COUNT (MAX_COUNT),
    .LFSR_W    (16),
    .SEED      (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  logic [15:0] mLfsr;
  always @(posedge clk) begin
    if (reset) mLfsr <= 16'hACE1;
    else       mLfsr <= lfsrStep(mLfsr);
  end

  int tcntM = 1;
  int expLast = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one request from an IDLE negedge and checks it against the reference model.
  task automatic doRoll(input string pfx, input int sides, input int count, input int tm,
                        input int pulse, output int oCyc, output int oRes, output int oLast);
    int  l, rem, sum, last, d, m, v, cyc, expDone;
    bit  ill;
    bus.sides = SW'(sides);
    bus.count = CW'(count);
`ifdef DICE_TEST_MODE_EN
    bus.test_mode = (tm != 0);
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    chk({pfx, "_busy"}, bus.busy, 1);
    l = int'(mLfsr);
    ill = (sides < 2) || (sides > MAX_SIDES) || (count == 0) || (count > MAX_COUNT);
    sum = 0; last = expLast; d = 0; rem = count;
    if (!ill) begin
      m = 0;
      while (m < sides - 1) m = m * 2 + 1;
      while (rem > 0 && d < 1000) begin
        l = int'(lfsrStep(16'(l)));
        d++;
        if (tm != 0) begin
          v = (tcntM > sides) ? 1 : tcntM;
          tcntM = v + 1;
        end else begin
          v = ((l & m) < sides) ? (l & m) + 1 : 0;
        end
        if (v != 0) begin sum += v; last = v; rem--; end
      end
      expDone = d + 2;
    end else begin
      expDone = 2;
    end
    while (bus.done !== 1'b1 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (pulse != 0 && cyc == 3) begin
        bus.start = 1'b1; bus.sides = SW'(2); bus.count = CW'(1);
      end else if (pulse != 0 && cyc == 4) begin
        bus.start = 1'b0;
      end
    end
    chk({pfx, "_done_cycle"}, cyc, expDone);
    chk({pfx, "_result"}, bus.result, sum);
    chk({pfx, "_last_die"}, bus.last_die, last);
    chk({pfx, "_error"}, bus.error, ill);
    oCyc = cyc; oRes = int'(bus.result); oLast = int'(bus.last_die);
    expLast = last;
    @(negedge clk);
    chk({pfx, "_done_drop"}, bus.done, 0);
    chk({pfx, "_idle"}, bus.busy, 0);
    if (pulse != 0) begin
      @(negedge clk);
      chk({pfx, "_no_queued_start"}, bus.busy, 0);
    end
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, res, last, prevLast, viol;
    logic [20:0] seen;
    bus.start = 1'b0;
    bus.sides = '0;
    bus.count = '0;
`ifdef DICE_TEST_MODE_EN
    bus.test_mode = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_last_die", bus.last_die, 0);

`ifdef DICE_TEST_MODE_EN
    doRoll("tm_6x3", 6, 3, 1, 0, cyc, res, last);
    chk("tm_6x3_hand_cycle", cyc, 5);
    chk("tm_6x3_hand_result", res, 6);
    chk("tm_6x3_hand_last", last, 3);
    doRoll("tm_20x2", 20, 2, 1, 0, cyc, res, last);
    chk("tm_20x2_hand_result", res, 9);
    chk("tm_20x2_hand_last", last, 5);
    doRoll("tm_4x1", 4, 1, 1, 0, cyc, res, last);
    chk("tm_4x1_hand_result", res, 1);
    chk("tm_4x1_hand_last", last, 1);
`endif

    doRoll("lf_6x3", 6, 3, 0, 0, cyc, res, last);
    doRoll("lf_20x2", 20, 2, 0, 0, cyc, res, last);
    doRoll("lf_2x5", 2, 5, 0, 0, cyc, res, last);
    doRoll("lf_100x8", 100, 8, 0, 0, cyc, res, last);
    doRoll("lf_7x1", 7, 1, 0, 0, cyc, res, last);

    prevLast = expLast;
    doRoll("ill_s1", 1, 2, 0, 0, cyc, res, last);
    chk("ill_s1_hand_cycle", cyc, 2);
    chk("ill_s1_hand_result", res, 0);
    chk("ill_s1_hand_last", last, prevLast);
    chk("ill_s1_hand_error", bus.error, 1);
    doRoll("ill_c0", 6, 0, 0, 0, cyc, res, last);
    chk("ill_c0_hand_cycle", cyc, 2);
    chk("ill_c0_hand_last", last, prevLast);
    doRoll("ill_c9", 6, 9, 0, 0, cyc, res, last);
    chk("ill_c9_hand_cycle", cyc, 2);
    chk("ill_c9_hand_result", res, 0);
    doRoll("ill_s101", 101, 1, 0, 0, cyc, res, last);
    chk("ill_s101_hand_cycle", cyc, 2);
    doRoll("after_ill", 12, 2, 0, 0, cyc, res, last);
    chk("after_ill_error_clear", bus.error, 0);

    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      doRoll("bulk", 20, 8, 0, 0, cyc, res, last);
      chk("bulk_range", (res >= 8 && res <= 160 && last >= 1 && last <= 20), 1);
      if (last >= 0 && last <= 20) seen[last] = 1'b1;
    end
    chk("bulk_faces", seen, 21'h1FFFFE);

    doRoll("busy_start", 20, 8, 0, 1, cyc, res, last);

    bus.sides = SW'(20);
    bus.count = CW'(8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tcntM = 1;
    expLast = 0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_error", bus.error, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_last_die", bus.last_die, 0);
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) viol++;
    end
    chk("midrst_quiet", viol, 0);
    doRoll("post_rst", 20, 3, 0, 0, cyc, res, last);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
